// File: rtl/cga_rgb_encoder_pkg.sv
// Shared constants, palette table and helpers for the RGB-to-CGA IRGB quantizer.
package cga_pkg;

  localparam int unsigned CHAN_W    = 6;
  localparam int unsigned DIST_W    = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned N_ENTRIES = 16;
  localparam int unsigned N_LEVELS  = 4;

  localparam logic [CHAN_W-1:0] L0 = 6'd0;
  localparam logic [CHAN_W-1:0] L1 = 6'd21;
  localparam logic [CHAN_W-1:0] L2 = 6'd42;
  localparam logic [CHAN_W-1:0] L3 = 6'd63;

  typedef logic [1:0] lvl_code_t;

  typedef struct packed {
    lvl_code_t r;
    lvl_code_t g;
    lvl_code_t b;
  } pal_entry_t;

  // Level codes per entry in R,G,B order; entry 6 is the brown special case.
  localparam pal_entry_t PALETTE [N_ENTRIES] = '{
    {2'd0, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd2}, {2'd0, 2'd2, 2'd0}, {2'd0, 2'd2, 2'd2},
    {2'd2, 2'd0, 2'd0}, {2'd2, 2'd0, 2'd2}, {2'd2, 2'd1, 2'd0}, {2'd2, 2'd2, 2'd2},
    {2'd1, 2'd1, 2'd1}, {2'd1, 2'd1, 2'd3}, {2'd1, 2'd3, 2'd1}, {2'd1, 2'd3, 2'd3},
    {2'd3, 2'd1, 2'd1}, {2'd3, 2'd1, 2'd3}, {2'd3, 2'd3, 2'd1}, {2'd3, 2'd3, 2'd3}
  };

  function automatic logic [CHAN_W-1:0] level_value(input lvl_code_t c);
    logic [CHAN_W-1:0] v;
    case (c)
      2'd0:    v = L0;
      2'd1:    v = L1;
      2'd2:    v = L2;
      default: v = L3;
    endcase
    return v;
  endfunction

  function automatic logic [CHAN_W-1:0] abs_diff(input logic [CHAN_W-1:0] a,
                                                 input logic [CHAN_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/cga_rgb_encoder_if.sv
// Pixel-in / palette-index-out bus of the RGB-to-CGA quantizer.
interface cga_rgb_encoder_if
  import cga_pkg::*;
#(
  parameter int unsigned SYNC_W = 3
);
  logic              in_valid;
  logic [CHAN_W-1:0] red;
  logic [CHAN_W-1:0] green;
  logic [CHAN_W-1:0] blue;
  logic [SYNC_W-1:0] side_in;
  logic              out_valid;
  logic [IDX_W-1:0]  video;
  logic [SYNC_W-1:0] side_out;
  logic              exact;

  modport master (
    output in_valid, red, green, blue, side_in,
    input  out_valid, video, side_out, exact
  );

  modport slave (
    input  in_valid, red, green, blue, side_in,
    output out_valid, video, side_out, exact
  );
endinterface

// File: rtl/cga_rgb_encoder_argmin16.sv
// Combinational 16-way minimum-with-index tree; ties go to the lower index.
module cga_argmin16
  import cga_pkg::*;
(
  input  logic [N_ENTRIES-1:0][DIST_W-1:0] dist_i,
  output logic [IDX_W-1:0]                 index_o,
  output logic [DIST_W-1:0]                min_o
);

  logic [7:0][DIST_W-1:0] m1;
  logic [7:0][IDX_W-1:0]  i1;
  logic [3:0][DIST_W-1:0] m2;
  logic [3:0][IDX_W-1:0]  i2;
  logic [1:0][DIST_W-1:0] m3;
  logic [1:0][IDX_W-1:0]  i3;

  // Left operand always covers the lower indices, so strict < keeps the lower one on ties.
  always_comb begin
    m1 = '0;
    i1 = '0;
    m2 = '0;
    i2 = '0;
    m3 = '0;
    i3 = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (dist_i[2*k+1] < dist_i[2*k]) begin
        m1[k] = dist_i[2*k+1];
        i1[k] = IDX_W'(2*k+1);
      end else begin
        m1[k] = dist_i[2*k];
        i1[k] = IDX_W'(2*k);
      end
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (m1[2*k+1] < m1[2*k]) begin
        m2[k] = m1[2*k+1];
        i2[k] = i1[2*k+1];
      end else begin
        m2[k] = m1[2*k];
        i2[k] = i1[2*k];
      end
    end
    for (int unsigned k = 0; k < 2; k++) begin
      if (m2[2*k+1] < m2[2*k]) begin
        m3[k] = m2[2*k+1];
        i3[k] = i2[2*k+1];
      end else begin
        m3[k] = m2[2*k];
        i3[k] = i2[2*k];
      end
    end
  end

  assign index_o = (m3[1] < m3[0]) ? i3[1] : i3[0];
  assign min_o   = (m3[1] < m3[0]) ? m3[1] : m3[0];

endmodule

// File: rtl/cga_rgb_encoder.sv
// 3-stage RGB666 to CGA IRGB nearest-palette quantizer with aligned sideband.
module cga_rgb_encoder
  import cga_pkg::*;
#(
  parameter int unsigned SYNC_W    = 3,
  parameter int unsigned BLANK_BIT = 2
)(
  input  logic               clk,
  input  logic               reset_n,
  cga_rgb_encoder_if.slave   bus
);

  // Stage 1: per-channel distance to each of the four levels
  logic [N_LEVELS-1:0][CHAN_W-1:0] absr_d, absg_d, absb_d;
  logic [N_LEVELS-1:0][CHAN_W-1:0] absr_q, absg_q, absb_q;
  logic                            v1_q;
  logic [SYNC_W-1:0]               side1_q;

  always_comb begin
    absr_d = '0;
    absg_d = '0;
    absb_d = '0;
    for (int unsigned k = 0; k < N_LEVELS; k++) begin
      absr_d[k] = abs_diff(bus.red,   level_value(lvl_code_t'(k)));
      absg_d[k] = abs_diff(bus.green, level_value(lvl_code_t'(k)));
      absb_d[k] = abs_diff(bus.blue,  level_value(lvl_code_t'(k)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      side1_q <= '0;
      absr_q  <= '0;
      absg_q  <= '0;
      absb_q  <= '0;
    end else begin
      v1_q    <= bus.in_valid;
      side1_q <= bus.side_in;
      absr_q  <= absr_d;
      absg_q  <= absg_d;
      absb_q  <= absb_d;
    end
  end

  // Stage 2: Manhattan distance per palette entry (max 3*63 fits 8 bits)
  logic [N_ENTRIES-1:0][DIST_W-1:0] dist_d, dist_q;
  logic                             v2_q;
  logic [SYNC_W-1:0]                side2_q;

  always_comb begin
    dist_d = '0;
    for (int unsigned e = 0; e < N_ENTRIES; e++) begin
      dist_d[e] = DIST_W'(absr_q[PALETTE[e].r])
                + DIST_W'(absg_q[PALETTE[e].g])
                + DIST_W'(absb_q[PALETTE[e].b]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_q    <= 1'b0;
      side2_q <= '0;
      dist_q  <= '0;
    end else begin
      v2_q    <= v1_q;
      side2_q <= side1_q;
      dist_q  <= dist_d;
    end
  end

  // Stage 3: argmin, blanking, output registers
  logic [IDX_W-1:0]  best_idx;
  logic [DIST_W-1:0] best_min;
  logic              blank;
  logic [IDX_W-1:0]  video_d, video_q;
  logic              exact_d, exact_q;
  logic              out_valid_q;
  logic [SYNC_W-1:0] side_out_q;

  cga_argmin16 u_argmin (
    .dist_i  (dist_q),
    .index_o (best_idx),
    .min_o   (best_min)
  );

  assign blank = side2_q[BLANK_BIT];

  // Video/exact only update on valid pixels; otherwise they hold.
  always_comb begin
    video_d = video_q;
    exact_d = exact_q;
    if (v2_q) begin
      video_d = blank ? '0 : best_idx;
      exact_d = !blank && (best_min == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      side_out_q  <= '0;
      video_q     <= '0;
      exact_q     <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      side_out_q  <= side2_q;
      video_q     <= video_d;
      exact_q     <= exact_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.side_out  = side_out_q;
  assign bus.video     = video_q;
  assign bus.exact     = exact_q;

endmodule

// File: tb/tb_cga_rgb_encoder.sv
// Directed/table bench for cga_rgb_encoder: palette, nearest, blanking, gaps, reset.
module tb_cga_rgb_encoder;

  logic clk = 1'b0;
  logic reset_n;

  cga_rgb_encoder_if #(.SYNC_W(3)) bus ();

  cga_rgb_encoder #(.SYNC_W(3), .BLANK_BIT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic [2:0] side;
    logic [3:0] exp_video;
    logic       exp_exact;
  } vec_t;

  vec_t tbl[$];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [3:0]  held_video = 4'h0;
  logic        held_exact = 1'b0;

  int unsigned LV [4]  = '{0, 21, 42, 63};
  int unsigned PR [16] = '{0,0,0,0, 2,2,2,2, 1,1,1,1, 3,3,3,3};
  int unsigned PG [16] = '{0,0,2,2, 0,0,1,2, 1,1,3,3, 1,1,3,3};
  int unsigned PB [16] = '{0,2,0,2, 0,2,0,2, 1,3,1,3, 1,3,1,3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input logic [2:0] s);
    bus.in_valid = v;
    bus.red      = r;
    bus.green    = g;
    bus.blue     = b;
    bus.side_in  = s;
  endtask

  function automatic int unsigned ad(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic void ref_model(input logic [5:0] r, input logic [5:0] g,
                                    input logic [5:0] b, output logic [3:0] idx,
                                    output int unsigned dmin);
    int unsigned d;
    dmin = 1000;
    idx  = 4'h0;
    for (int e = 0; e < 16; e++) begin
      d = ad(r, LV[PR[e]]) + ad(g, LV[PG[e]]) + ad(b, LV[PB[e]]);
      if (d < dmin) begin
        dmin = d;
        idx  = 4'(e);
      end
    end
  endfunction

  function automatic void add(input logic v, input logic [5:0] r, input logic [5:0] g,
                              input logic [5:0] b, input logic [2:0] s,
                              input logic [3:0] ev, input logic ee);
    vec_t t;
    t.vld = v; t.r = r; t.g = g; t.b = b; t.side = s;
    t.exp_video = ev; t.exp_exact = ee;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [3:0]  m_idx;
    int unsigned m_d;
    logic [5:0]  rr, gg, bb;
    logic        vv;
    logic [2:0]  ss;
    int          n;
    int          lat;
    logic        found;

    // Palette round trip: every exact entry maps back to its own index.
    for (int i = 0; i < 16; i++)
      add(1'b1, 6'(LV[PR[i]]), 6'(LV[PG[i]]), 6'(LV[PB[i]]), 3'b000, 4'(i), 1'b1);
    // Nearest, brown and tie cases (hand-computed)
    add(1'b1, 6'd42, 6'd42, 6'd0,  3'b000, 4'h6, 1'b0);
    add(1'b1, 6'd32, 6'd32, 6'd32, 3'b000, 4'h7, 1'b0);
    add(1'b1, 6'd21, 6'd21, 6'd0,  3'b000, 4'h6, 1'b0);
    // Blank forces black; sync-only sideband passes through
    add(1'b1, 6'd63, 6'd63, 6'd63, 3'b100, 4'h0, 1'b0);
    add(1'b0, 6'd63, 6'd63, 6'd63, 3'b001, 4'h0, 1'b0);
    add(1'b1, 6'd63, 6'd63, 6'd63, 3'b010, 4'hF, 1'b1);
    add(1'b0, 6'd0,  6'd0,  6'd0,  3'b011, 4'h0, 1'b0);
    add(1'b1, 6'd10, 6'd11, 6'd10, 3'b000, 4'h0, 1'b0);
    // Random stream with gaps
    for (int i = 0; i < 100; i++) begin
      vv = 1'($urandom_range(0, 1));
      rr = 6'($urandom_range(0, 63));
      gg = 6'($urandom_range(0, 63));
      bb = 6'($urandom_range(0, 63));
      ss = {($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3))};
      ref_model(rr, gg, bb, m_idx, m_d);
      if (ss[2]) add(vv, rr, gg, bb, ss, 4'h0, 1'b0);
      else       add(vv, rr, gg, bb, ss, m_idx, (m_d == 0));
    end

    // Reset state
    drive(1'b0, 6'd0, 6'd0, 6'd0, 3'b000);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_video",     bus.video,     4'h0);
    check("rst_side_out",  bus.side_out,  3'b000);
    check("rst_exact",     bus.exact,     1'b0);
    reset_n = 1'b1;

    // Table-driven stream: outputs after edge i belong to vector i-2
    n = tbl.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive(tbl[i].vld, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].side);
      else       drive(1'b0, 6'd0, 6'd0, 6'd0, 3'b000);
      @(posedge clk);
      @(negedge clk);
      if (i >= 2) begin
        vec_t v;
        v = tbl[i-2];
        if (v.vld) begin
          held_video = v.exp_video;
          held_exact = v.exp_exact;
        end
        check($sformatf("vec%0d_valid", i-2), bus.out_valid, v.vld);
        check($sformatf("vec%0d_side",  i-2), bus.side_out,  v.side);
        check($sformatf("vec%0d_video", i-2), bus.video,     held_video);
        check($sformatf("vec%0d_exact", i-2), bus.exact,     held_exact);
      end
    end

    // Reset mid-stream with pixels in flight
    drive(1'b1, 6'd63, 6'd63, 6'd63, 3'b011);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_valid", bus.out_valid, 1'b1);
    check("pre_rst_video", bus.video,     4'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 1'b0);
    check("async_rst_video", bus.video,     4'h0);
    check("async_rst_side",  bus.side_out,  3'b000);
    check("async_rst_exact", bus.exact,     1'b0);
    drive(1'b0, 6'd0, 6'd0, 6'd0, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("no_stale_%0d", c), bus.out_valid, 1'b0);
    end

    // Post-reset latency, bounded wait
    drive(1'b1, 6'd21, 6'd21, 6'd63, 3'b000);
    lat   = 10;
    found = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 6'd0, 6'd0, 6'd0, 3'b000);
      if (bus.out_valid) begin
        found = 1'b1;
        lat   = c;
      end
    end
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_video",   bus.video, 4'h9);
    check("post_rst_exact",   bus.exact, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
